// File: rtl/tile_fragment_walker_pkg.sv
// Shared fixed-point constants and types for the tile fragment walker.
// TILE_WIDTH_BITS sets the default tile size.
package tile_fragment_walker_pkg;

    localparam int unsigned FX_INT_BITS   = 12;
    localparam int unsigned FX_FRAC_BITS  = 4;
    localparam int unsigned FX_TOTAL_BITS = FX_INT_BITS + FX_FRAC_BITS;
    localparam int unsigned ACC_BITS      = 2 * FX_TOTAL_BITS;

    localparam int unsigned TILE_WIDTH_BITS = 2;

    typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;
    typedef logic signed [ACC_BITS-1:0]      acc_t;
    typedef logic [15:0]                     metadata_t;

    typedef struct packed {
        fx_t x;
        fx_t y;
        fx_t z;
    } coord_3d_t;

    typedef enum logic [1:0] {IDLE, WALK, DRAIN} walker_state_t;

    typedef struct packed {
        logic [FX_INT_BITS-1:0] x;
        logic [FX_INT_BITS-1:0] y;
        fx_t                    z;
        metadata_t              metadata;
    } fragment_t;

    typedef enum logic [1:0] {ACC_HOLD, ACC_LOAD, ACC_STEP_X, ACC_STEP_Y} acc_op_t;

    // 12.4 slope into the accumulator's 2*FX_FRAC_BITS fraction format
    function automatic acc_t fx_to_acc(input fx_t v);
        return acc_t'(v) <<< FX_FRAC_BITS;
    endfunction

endpackage

// File: rtl/tile_fragment_walker_edge.sv
// edge_accumulator: signed accumulator with a row-start copy, so each new row
// restarts from an exact value instead of carrying x-step error.
module edge_accumulator
    import tile_fragment_walker_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  acc_op_t op,
    input  acc_t    load_val,
    input  acc_t    step_x,
    input  acc_t    step_y,
    output acc_t    value
);

    acc_t acc_q, acc_d;
    acc_t row_q, row_d;

    always_comb begin
        acc_d = acc_q;
        row_d = row_q;
        unique case (op)
            ACC_LOAD: begin
                acc_d = load_val;
                row_d = load_val;
            end
            ACC_STEP_X: acc_d = acc_q + step_x;
            ACC_STEP_Y: begin
                row_d = row_q + step_y;
                acc_d = row_q + step_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            row_q <= '0;
        end else begin
            acc_q <= acc_d;
            row_q <= row_d;
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/tile_fragment_walker.sv
// Tile rasteriser back end: walks a 2^TILE_BITS square tile in raster order, one pixel per cycle,
// emitting covered fragments. Define WALKER_FRAG_COUNT_EN to add the frag_count output.
module tile_fragment_walker
    import tile_fragment_walker_pkg::*;
#(
    parameter int unsigned TILE_BITS = TILE_WIDTH_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld_in,
    output logic                   rdy_in,
    input  coord_3d_t              in_abs_pos,
    input  coord_3d_t              in_delta_0,
    input  coord_3d_t              in_delta_1,
    input  coord_3d_t              in_delta_2,
    input  acc_t                   in_edge_0,
    input  acc_t                   in_edge_1,
    input  acc_t                   in_edge_2,
    input  fx_t                    in_dzdx,
    input  fx_t                    in_dzdy,
    input  acc_t                   in_z_current,
    input  metadata_t              in_metadata,
    output logic                   vld_out,
    input  logic                   rdy_out,
    output logic [FX_INT_BITS-1:0] frag_x,
    output logic [FX_INT_BITS-1:0] frag_y,
    output fx_t                    frag_z,
    output metadata_t              frag_metadata,
`ifdef WALKER_FRAG_COUNT_EN
    output logic [2*TILE_BITS:0]   frag_count,
`endif
    output logic                   tile_done
);

    localparam logic [TILE_BITS-1:0] PIX_MAX = '1;

    walker_state_t          state_q, state_d;
    logic [TILE_BITS-1:0]   px_q, px_d, py_q, py_d;
    logic [FX_INT_BITS-1:0] org_x_q, org_y_q;
    fx_t                    dx_q [3];
    fx_t                    dy_q [3];
    fx_t                    dzdx_q, dzdy_q;
    metadata_t              meta_q;
    logic                   vld_q, vld_d;
    logic                   done_q, done_d;
    fragment_t              frag_q, frag_d;

    acc_op_t acc_op;
    acc_t    edge_init [3];
    acc_t    edge_val  [3];
    acc_t    z_val;
    logic    accept, stall, covered, frag_load;
    logic    unused_bits;

    assign edge_init[0] = in_edge_0;
    assign edge_init[1] = in_edge_1;
    assign edge_init[2] = in_edge_2;

    for (genvar g = 0; g < 3; g++) begin : g_edge
        edge_accumulator u_edge (
            .clk      (clk),
            .rst      (rst),
            .op       (acc_op),
            .load_val (edge_init[g]),
            .step_x   (fx_to_acc(dy_q[g])),
            .step_y   (-fx_to_acc(dx_q[g])),
            .value    (edge_val[g])
        );
    end

    edge_accumulator u_z (
        .clk      (clk),
        .rst      (rst),
        .op       (acc_op),
        .load_val (in_z_current),
        .step_x   (fx_to_acc(dzdx_q)),
        .step_y   (fx_to_acc(dzdy_q)),
        .value    (z_val)
    );

    assign rdy_in  = (state_q == IDLE) && !rst;
    assign accept  = vld_in && rdy_in;
    assign stall   = vld_q && !rdy_out;
    // Zero on an edge counts as inside
    assign covered = !edge_val[0][ACC_BITS-1] && !edge_val[1][ACC_BITS-1] &&
                     !edge_val[2][ACC_BITS-1];

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        vld_d     = vld_q;
        done_d    = 1'b0;
        frag_d    = frag_q;
        acc_op    = ACC_HOLD;
        frag_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    px_d    = '0;
                    py_d    = '0;
                    acc_op  = ACC_LOAD;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (!stall) begin
                    if (covered) begin
                        vld_d           = 1'b1;
                        frag_load       = 1'b1;
                        frag_d.x        = org_x_q + {{(FX_INT_BITS-TILE_BITS){1'b0}}, px_q};
                        frag_d.y        = org_y_q + {{(FX_INT_BITS-TILE_BITS){1'b0}}, py_q};
                        frag_d.z        = z_val[FX_TOTAL_BITS-1+FX_FRAC_BITS:FX_FRAC_BITS];
                        frag_d.metadata = meta_q;
                    end else if (rdy_out) begin
                        vld_d = 1'b0;
                    end
                    if (px_q == PIX_MAX) begin
                        px_d   = '0;
                        py_d   = py_q + 1'b1;
                        acc_op = ACC_STEP_Y;
                        if (py_q == PIX_MAX) state_d = DRAIN;
                    end else begin
                        px_d   = px_q + 1'b1;
                        acc_op = ACC_STEP_X;
                    end
                end
            end
            DRAIN: begin
                if (!vld_q || rdy_out) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            org_x_q <= '0;
            org_y_q <= '0;
            dzdx_q  <= '0;
            dzdy_q  <= '0;
            meta_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            frag_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            frag_q  <= frag_d;
            if (accept) begin
                org_x_q <= in_abs_pos.x[FX_TOTAL_BITS-1:FX_FRAC_BITS];
                org_y_q <= in_abs_pos.y[FX_TOTAL_BITS-1:FX_FRAC_BITS];
                dzdx_q  <= in_dzdx;
                dzdy_q  <= in_dzdy;
                meta_q  <= in_metadata;
                dx_q[0] <= in_delta_0.x;
                dy_q[0] <= in_delta_0.y;
                dx_q[1] <= in_delta_1.x;
                dy_q[1] <= in_delta_1.y;
                dx_q[2] <= in_delta_2.x;
                dy_q[2] <= in_delta_2.y;
            end
        end
    end

`ifdef WALKER_FRAG_COUNT_EN
    logic [2*TILE_BITS:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (frag_load) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign frag_count = cnt_q;
`endif

    assign vld_out       = vld_q;
    assign tile_done     = done_q;
    assign frag_x        = frag_q.x;
    assign frag_y        = frag_q.y;
    assign frag_z        = frag_q.z;
    assign frag_metadata = frag_q.metadata;

    // Fraction bits, z deltas and most accumulator bits are not needed downstream
    assign unused_bits = ^{in_abs_pos.z, in_abs_pos.x[FX_FRAC_BITS-1:0],
                           in_abs_pos.y[FX_FRAC_BITS-1:0], in_delta_0.z, in_delta_1.z,
                           in_delta_2.z, edge_val[0], edge_val[1], edge_val[2], z_val,
                           frag_load};

endmodule
